sha3_digest_reader: RTL and testbench



---
 rtl/sha3_pkg.sv | 16 +
 rtl/sha3_digest_reader.sv | 106 ++++++++++
 tb/tb_sha3_digest_reader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared SHA3 bus constants and the digest-reader state encoding.
package sha3_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned DIGEST_WORDS = 16;
  localparam int unsigned RATE_WORDS   = 18;

  localparam logic [WORD_W-1:0] READ_ADDR  = 32'h56;
  localparam logic [WORD_W-1:0] WRITE_ADDR = 32'h55;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/sha3_digest_reader.sv
// Captures a wide SHA3 digest and serves it LSW-first, one 32-bit word per bus read.
// Optional: define SHA3_READER_ZEROIZE_EN to clear each buffer word as it is read out.
module sha3_digest_reader #(
  parameter int unsigned WORDS     = sha3_pkg::DIGEST_WORDS,
  parameter logic [31:0] READ_ADDR = sha3_pkg::READ_ADDR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                digest_valid,
  input  logic [WORDS*32-1:0] digest_in,
  output logic                digest_ack,
  input  logic                read_e,
  input  logic [31:0]         addr_in,
  output logic [31:0]         data_out,
  output logic                data_valid,
  output logic                avail,
  output logic                underrun,
  output logic                done
);

  import sha3_pkg::*;

  localparam int unsigned DIGEST_W = WORDS * WORD_W;
  localparam int unsigned IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t               state, state_d;
  logic [DIGEST_W-1:0]  digest_buf, digest_buf_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [WORD_W-1:0]    data_out_d;
  logic                 ack_d, data_valid_d, underrun_d, done_d;
  logic                 rd_hit;

  assign rd_hit = read_e && (addr_in == READ_ADDR);
  assign avail  = (state == SERVE);

  // Next-state, buffer and output-pulse logic.
  always_comb begin
    state_d      = state;
    digest_buf_d = digest_buf;
    idx_d        = idx;
    data_out_d   = data_out;
    ack_d        = 1'b0;
    data_valid_d = 1'b0;
    underrun_d   = 1'b0;
    done_d       = 1'b0;
    case (state)
      IDLE: begin
        // The bus never stalls: an empty read still completes, with zero data.
        if (rd_hit) begin
          data_out_d   = '0;
          data_valid_d = 1'b1;
          underrun_d   = 1'b1;
        end
        if (digest_valid) begin
          digest_buf_d = digest_in;
          idx_d        = '0;
          ack_d        = 1'b1;
          state_d      = SERVE;
        end
      end
      SERVE: begin
        if (rd_hit) begin
          data_out_d   = digest_buf[WORD_W*idx +: WORD_W];
          data_valid_d = 1'b1;
`ifdef SHA3_READER_ZEROIZE_EN
          digest_buf_d[WORD_W*idx +: WORD_W] = '0;
`else
          digest_buf_d = digest_buf;
`endif
          if (idx == LAST_IDX) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      digest_buf <= '0;
      idx        <= '0;
      data_out   <= '0;
      digest_ack <= 1'b0;
      data_valid <= 1'b0;
      underrun   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      digest_buf <= digest_buf_d;
      idx        <= idx_d;
      data_out   <= data_out_d;
      digest_ack <= ack_d;
      data_valid <= data_valid_d;
      underrun   <= underrun_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_sha3_digest_reader.sv
// Directed plus randomized bench for sha3_digest_reader against a queue-based reference model.
module tb_sha3_digest_reader;
  import sha3_pkg::*;

  localparam int unsigned NW = DIGEST_WORDS;
  localparam int unsigned DW = NW * 32;

  logic          clk, rst, digest_valid, read_e;
  logic [DW-1:0] digest_in;
  logic [31:0]   addr_in, data_out;
  logic          digest_ack, data_valid, avail, underrun, done;

  sha3_digest_reader dut (
    .clk(clk), .rst(rst), .digest_valid(digest_valid), .digest_in(digest_in),
    .digest_ack(digest_ack), .read_e(read_e), .addr_in(addr_in), .data_out(data_out),
    .data_valid(data_valid), .avail(avail), .underrun(underrun), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  // Reference model: words still owed to the bus, plus expected registered outputs.
  logic [31:0]   q[$];
  logic [DW-1:0] last_digest = '0;
  logic [31:0]   e_data = '0;
  logic          e_ack = 0, e_dv = 0, e_und = 0, e_done = 0, e_avail = 0;

  // Producer: holds its digest until it sees an ack.
  logic          pend = 0;
  logic [DW-1:0] pend_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic dv, input logic [DW-1:0] d,
                       input logic re, input logic [31:0] a);
    logic acc;
    if (r) begin
      q.delete();
      e_data = '0; e_ack = 0; e_dv = 0; e_und = 0; e_done = 0;
    end else begin
      e_ack = 0; e_dv = 0; e_und = 0; e_done = 0;
      acc = re && (a == 32'h56);
      if (q.size() > 0) begin
        if (acc) begin
          e_data = q.pop_front();
          e_dv   = 1;
          e_done = (q.size() == 0);
        end
      end else begin
        if (acc) begin
          e_data = '0; e_dv = 1; e_und = 1;
        end
        if (dv) begin
          for (int i = 0; i < NW; i++) q.push_back(d[32*i +: 32]);
          last_digest = d;
          e_ack = 1;
        end
      end
    end
    e_avail = (q.size() > 0);
  endtask

  task automatic step(input logic r, input logic re, input logic [31:0] a);
    logic          dv_now;
    logic [DW-1:0] d_now;
    dv_now = pend; d_now = pend_data;
    rst = r; digest_valid = dv_now; digest_in = d_now; read_e = re; addr_in = a;
    @(posedge clk); #1;
    model(r, dv_now, d_now, re, a);
    chk("digest_ack", 32'(digest_ack), 32'(e_ack));
    chk("data_valid", 32'(data_valid), 32'(e_dv));
    chk("data_out",   data_out,        e_data);
    chk("underrun",   32'(underrun),   32'(e_und));
    chk("done",       32'(done),       32'(e_done));
    chk("avail",      32'(avail),      32'(e_avail));
    if (e_ack || r) pend = 0;
  endtask

  task automatic present(input logic [DW-1:0] d);
    pend = 1; pend_data = d;
  endtask

  function automatic logic [DW-1:0] pattern(input logic [31:0] base);
    logic [DW-1:0] v;
    for (int i = 0; i < NW; i++) v[32*i +: 32] = base + 32'(i);
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_digest();
    logic [DW-1:0] v;
    for (int i = 0; i < NW; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    rst = 1; digest_valid = 0; digest_in = '0; read_e = 0; addr_in = '0;

    // Reset state, then an underrun read from IDLE.
    step(1, 0, 32'h0);
    step(1, 0, 32'h0);
    step(0, 1, 32'h56);
    step(0, 0, 32'h0);

    // Load A-pattern and drain it, with a wrong-address read mixed in.
    present(pattern(32'hA000_0000));
    step(0, 0, 32'h0);
    for (int i = 0; i < NW; i++) begin
      if (i == 3) step(0, 1, 32'h55);
      step(0, 1, 32'h56);
    end
    step(0, 0, 32'h0);

    // Buffer residue after a full drain depends on the zeroize build.
    for (int i = 0; i < NW; i++) begin
`ifdef SHA3_READER_ZEROIZE_EN
      chk("buf_after_drain", dut.digest_buf[32*i +: 32], 32'h0);
`else
      chk("buf_after_drain", dut.digest_buf[32*i +: 32], last_digest[32*i +: 32]);
`endif
    end

    // Hold-off: new digest offered mid-drain is acked only after the final read.
    present(rand_digest());
    step(0, 0, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'h56);
    present(pattern(32'hB000_0000));
    for (int i = 0; i < NW - 5; i++) step(0, 1, 32'h56);
    step(0, 0, 32'h0);
    for (int i = 0; i < NW; i++) step(0, 1, 32'h56);

    // Reset mid-serve abandons the rest; the next read underruns.
    present(rand_digest());
    step(0, 0, 32'h0);
    for (int i = 0; i < 7; i++) step(0, 1, 32'h56);
    step(1, 0, 32'h0);
    step(0, 1, 32'h56);

    // Randomized traffic, including occasional resets and near-miss addresses.
    for (int c = 0; c < 600; c++) begin
      logic        re, r;
      logic [31:0] a;
      if (!pend && ($urandom % 6 == 0)) present(rand_digest());
      re = ($urandom % 10) < 7;
      case ($urandom % 6)
        0: a = 32'h55;
        1: a = $urandom;
        default: a = 32'h56;
      endcase
      r = ($urandom % 150) == 0;
      step(r, re, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
